clock_period_meter: RTL and testbench
=====================================

// Module: clock_period_meter
// PURPOSE
//  Receive-side monitor for a divided clock: measures a slow periodic input
//  (e.g. variable_clock_divider clk_out) in units of clk_in cycles.
//  Reports period, high time, one-cycle measurement strobe, lock and stall flags.
//  Sits beside the LED controller's clock divider for self-check and runtime monitoring.
// PARAMETERS
//  WIDTH  16  bit width of counters and of period/high_time outputs; MAX = 2**WIDTH-1
// PORTS
//  clk_in     input   1      sole clock, rising edge
//  reset      input   1      synchronous, active-high
//  sleep      input   1      freeze: hold all state and outputs
//  sig_in     input   1      signal under measurement
//  period     output  WIDTH  clk_in cycles between last two sig_in rising edges
//  high_time  output  WIDTH  clk_in cycles sig_in was high in the last high phase
//  meas_valid output  1      one-cycle strobe when period updates
//  locked     output  1      last two periods equal
//  stalled    output  1      no rising edge within MAX cycles
// BEHAVIOUR
//  - Reset: dominates sleep; all outputs 0, counters 0, state IDLE; discards any partial measurement.
//  - Input path: sig_s <= sig_in (optional sync first); sig_d <= sig_s.
//    rise = sig_s & ~sig_d; fall = ~sig_s & sig_d.
//  - cnt: on rise, cnt <= 1; else cnt <= cnt+1, saturating at MAX.
//  - hcnt: on rise, hcnt <= 1; else if sig_s, hcnt <= hcnt+1, saturating at MAX.
//  - FSM IDLE: wait for first rise -> MEASURE; no outputs change.
//  - FSM MEASURE, on rise:
//      period <= cnt; meas_valid <= 1 for one cycle; stalled <= 0.
//      locked <= (cnt == period) && previous measurement exists.
//      Result: rises P cycles apart give period = P.
//  - FSM MEASURE, on fall: high_time <= hcnt, i.e. H cycles high gives high_time = H.
//    high_time updates in any state once hcnt has started.
//  - Stall: in MEASURE, cnt == MAX with no rise -> stalled <= 1, locked <= 0, -> IDLE.
//    period and high_time hold. stalled clears on the next meas_valid.
//  - Sleep=1: all registers hold, including sig_s/sig_d, and meas_valid forced 0.
//    On sleep falling: locked <= 0, -> IDLE, so the first period after wake is discarded.
//  - Latency: meas_valid and period are visible after the 2nd clk_in edge following
//    the edge that first samples sig_in high.
//  - Minimum measurable period is 2; minimum high_time is 1.
//  - Constant sig_in (0 or 1) ends in a stall.
// CONFIGURATION
//  CLK_METER_SYNC_EN defined:
//    - Two-flop synchroniser ahead of sig_s; sig_in may be asynchronous to clk_in.
//    - Latency grows by 2 cycles (4th edge). Measured values are unchanged.
//    - Sync flops are cleared by reset and held by sleep.
//  CLK_METER_SYNC_EN undefined:
//    - sig_in must be synchronous to clk_in; sampled directly into sig_s.
// TESTING
//  1. reset=1 for 2 cycles with sig_in toggling
//     -> period=0, high_time=0, meas_valid=0, locked=0, stalled=0.
//  2. sig_in period 10, high 5, steady
//     -> first meas_valid at 2nd rise with period=10, high_time=5, locked=0;
//        3rd rise gives locked=1.
//  3. Period changes 10 -> 16 (high 8)
//     -> next strobe: period=16, high_time=8, locked=0; following strobe locked=1.
//  4. WIDTH=8, sig_in held 0 after lock
//     -> stalled=1 when 255 cycles pass without a rise; locked=0; period holds 10.
//        Restart at period 10: first rise gives no strobe; second rise gives
//        meas_valid, period=10, stalled=0.
//  5. sleep=1 mid-period for 7 cycles, then 0
//     -> no meas_valid while asleep; locked=0 on wake; first post-wake rise gives no strobe.
//  6. reset pulse mid-period while locked
//     -> all outputs 0 next cycle; re-measure as in 2.
//     With CLK_METER_SYNC_EN, repeat 2 with async sig_in
//     -> period within +/-1 of 10, strobe 2 cycles later.

Source files
------------

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow input in clk_in cycles.
// Build option: define CLK_METER_SYNC_EN to add a two-flop synchroniser ahead of the edge detector.
module clock_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sleep,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           r_state, w_state_next;
  logic             r_sig_s, r_sig_d, r_sleep_d, r_have_prev;
  logic [WIDTH-1:0] r_cnt, r_hcnt, r_period, r_high_time;
  logic             r_meas_valid, r_locked, r_stalled;
  logic             w_sample, w_rise, w_fall, w_active, w_wake, w_measure, w_stall;

`ifdef CLK_METER_SYNC_EN
  logic r_sync1, r_sync2;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else if (!sleep) begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = sig_in;
`endif

  assign w_rise   = r_sig_s & ~r_sig_d;
  assign w_fall   = ~r_sig_s & r_sig_d;
  assign w_active = ~sleep;
  assign w_wake   = w_active & r_sleep_d;
  // A wake cycle never produces a strobe or a stall: the first period after sleep is discarded.
  assign w_measure = w_active & ~w_wake & (r_state == MEASURE) & w_rise;
  assign w_stall   = w_active & ~w_wake & (r_state == MEASURE) & ~w_rise & (r_cnt == MAX_COUNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sig_s   <= 1'b0;
      r_sig_d   <= 1'b0;
      r_sleep_d <= 1'b0;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_state   <= IDLE;
    end else begin
      r_sleep_d <= sleep;
      r_state   <= w_state_next;
      if (w_active) begin
        r_sig_s <= w_sample;
        r_sig_d <= r_sig_s;
        if (w_rise)                  r_cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
        else if (r_cnt != MAX_COUNT) r_cnt <= r_cnt + 1'b1;
        if (w_rise)                                r_hcnt <= {{(WIDTH-1){1'b0}}, 1'b1};
        else if (r_sig_s && r_hcnt != MAX_COUNT)   r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  // NOTE: the default is assigned first so no path leaves w_state_next unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    if (w_active) begin
      if (w_wake) begin
        w_state_next = w_rise ? MEASURE : IDLE;
      end else begin
        unique case (r_state)
          IDLE:    if (w_rise)  w_state_next = MEASURE;
          MEASURE: if (w_stall) w_state_next = IDLE;
          default: w_state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_stalled    <= 1'b0;
      r_have_prev  <= 1'b0;
    end else begin
      r_meas_valid <= w_measure;
      if (w_measure) begin
        r_period    <= r_cnt;
        r_stalled   <= 1'b0;
        r_locked    <= (r_cnt == r_period) && r_have_prev;
        r_have_prev <= 1'b1;
      end else if (w_stall) begin
        r_stalled   <= 1'b1;
        r_locked    <= 1'b0;
        r_have_prev <= 1'b0;
      end else if (w_wake) begin
        r_locked    <= 1'b0;
        r_have_prev <= 1'b0;
      end
      // hcnt is zero only before the first rise after reset.
      if (w_active && w_fall && r_hcnt != '0) r_high_time <= r_hcnt;
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign stalled    = r_stalled;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: randomized scoreboard bench; an event-level timing model predicts
// each strobe (period, high time, lock) and the held output levels.
module tb_clock_period_meter;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk_in = 1'b0;
  logic         reset  = 1'b1;
  logic         sleep  = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic         meas_valid, locked, stalled;

  clock_period_meter #(.WIDTH(W)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .sleep      (sleep),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .stalled    (stalled)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int p;
    int h;
    bit lk;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pushed = 0;
  int   n_seen   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: time is the count of awake clock edges; a rise/fall seen on the
  // input becomes visible to the meter one awake edge after it is sampled.
  bit m_prev = 0, m_cur = 0, m_armed = 0, m_have_prev = 0, m_seen_rise = 0, m_was_asleep = 0;
  int m_t = 0, m_rise_t = 0;
  int exp_period = 0, exp_high = 0;
  bit exp_locked = 0, exp_stalled = 0;

  task automatic model_edge(input bit rst, input bit slp, input bit s);
    bit   rise, fall;
    int   p;
    exp_t e;
    if (rst) begin
      m_prev = 0; m_cur = 0; m_armed = 0; m_have_prev = 0; m_seen_rise = 0; m_was_asleep = 0;
      exp_period = 0; exp_high = 0; exp_locked = 0; exp_stalled = 0;
      return;
    end
    if (slp) begin
      m_was_asleep = 1;
      return;
    end
    rise = m_cur && !m_prev;
    fall = !m_cur && m_prev;
    if (m_was_asleep) begin
      m_armed = 0; m_have_prev = 0; exp_locked = 0; m_was_asleep = 0;
    end
    if (fall && m_seen_rise) exp_high = (m_t - m_rise_t > MAXV) ? MAXV : m_t - m_rise_t;
    if (rise) begin
      if (m_armed) begin
        p    = m_t - m_rise_t;
        e.p  = p;
        e.h  = exp_high;
        e.lk = m_have_prev && (p == exp_period);
        sb_q.push_back(e);
        n_pushed++;
        exp_locked  = e.lk;
        exp_period  = p;
        exp_stalled = 0;
        m_have_prev = 1;
      end
      m_armed = 1; m_rise_t = m_t; m_seen_rise = 1;
    end else if (m_armed && (m_t - m_rise_t) >= MAXV) begin
      exp_stalled = 1; exp_locked = 0; m_armed = 0; m_have_prev = 0;
    end
    m_prev = m_cur;
    m_cur  = s;
    m_t++;
  endtask

  always @(posedge clk_in) model_edge(reset, sleep, sig_in);

  // Monitor: level outputs every cycle, strobes popped from the scoreboard.
  always @(negedge clk_in) begin
    exp_t e;
    check("period_level", int'(period), exp_period);
    check("high_time_level", int'(high_time), exp_high);
    check("locked_level", int'(locked), int'(exp_locked));
    check("stalled_level", int'(stalled), int'(exp_stalled));
    if (meas_valid) begin
      check("strobe_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_seen++;
        check("strobe_period", int'(period), e.p);
        check("strobe_high_time", int'(high_time), e.h);
        check("strobe_locked", int'(locked), int'(e.lk));
        check("strobe_stalled", int'(stalled), 0);
      end
    end
  end

  int ph = 0;
  int sleep_left = 0;

  task automatic drive(input int p, input int h, input int n, input bit slp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      sleep  = slp;
      sig_in = (ph % p) < h;
      ph++;
    end
  endtask

  task automatic drive_random(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      if (sleep_left > 0) begin
        sleep = 1'b1;
        sleep_left--;
      end else if ($urandom_range(0, 59) == 0) begin
        sleep      = 1'b1;
        sleep_left = $urandom_range(0, 7);
      end else begin
        sleep = 1'b0;
      end
      sig_in = (ph % p) < h;
      ph++;
    end
  endtask

  initial begin
    int p, h;
    // Reset with the input toggling.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in);
      #1;
      sig_in = ~sig_in;
    end
    @(negedge clk_in);
    check("rst_period", int'(period), 0);
    check("rst_high_time", int'(high_time), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_stalled", int'(stalled), 0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;

    // Steady period 10, high 5.
    ph = 0;
    drive(10, 5, 50, 1'b0);
    @(negedge clk_in);
    check("p10_period", int'(period), 10);
    check("p10_high_time", int'(high_time), 5);
    check("p10_locked", int'(locked), 1);

    // Period change to 16, high 8.
    ph = 0;
    drive(16, 8, 80, 1'b0);
    @(negedge clk_in);
    check("p16_period", int'(period), 16);
    check("p16_high_time", int'(high_time), 8);
    check("p16_locked", int'(locked), 1);

    // Back to 10, then hold low until a stall.
    ph = 0;
    drive(10, 5, 50, 1'b0);
    @(posedge clk_in);
    #1;
    sig_in = 1'b0;
    for (int i = 0; i < 300; i++) @(posedge clk_in);
    @(negedge clk_in);
    check("stall_flag", int'(stalled), 1);
    check("stall_locked", int'(locked), 0);
    check("stall_period_hold", int'(period), 10);
    ph = 0;
    drive(10, 5, 30, 1'b0);
    @(negedge clk_in);
    check("restart_period", int'(period), 10);
    check("restart_stalled", int'(stalled), 0);

    // Sleep for 7 cycles mid-period.
    drive(10, 5, 23, 1'b0);
    drive(10, 5, 7, 1'b1);
    drive(10, 5, 1, 1'b0);
    @(posedge clk_in);
    @(negedge clk_in);
    check("wake_locked", int'(locked), 0);
    drive(10, 5, 40, 1'b0);

    // Reset pulse mid-period while locked, then re-measure.
    drive(10, 5, 44, 1'b0);
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    check("rst2_period", int'(period), 0);
    check("rst2_locked", int'(locked), 0);
    check("rst2_high_time", int'(high_time), 0);
    #4;
    reset = 1'b0;
    ph = 0;
    drive(10, 5, 45, 1'b0);
    @(negedge clk_in);
    check("remeasure_locked", int'(locked), 1);

    // Randomized segments, including periods beyond the counter range and sleep bursts.
    for (int seg = 0; seg < 12; seg++) begin
      p  = (seg == 5) ? $urandom_range(200, 300) : $urandom_range(2, 40);
      h  = $urandom_range(1, p - 1);
      ph = $urandom_range(0, p - 1);
      drive_random(p, h, $urandom_range(p * 3, p * 6));
    end
    @(posedge clk_in);
    #1;
    sleep = 1'b0;
    drive(7, 3, 30, 1'b0);
    @(negedge clk_in);
    @(negedge clk_in);
    check("scoreboard_drained", sb_q.size(), 0);
    check("strobes_seen", n_seen, n_pushed);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
